load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response channel of the load/store unit.
// master = issuing pipeline, slave = LSU.
interface load_store_unit_if #(parameter int AWIDTH = 8);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [AWIDTH-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit over a 32-bit word memory. Sub-word stores
// at non-zero offsets are done as read-modify-write with a full-word write.

module lsu_merge_lane #(parameter int LANE = 0) (
  input  logic        is_half,
  input  logic [1:0]  off,
  input  logic [15:0] wdata,
  input  logic [7:0]  old_byte,
  output logic [7:0]  new_byte
);
  localparam logic [1:0] L = 2'(LANE);
  logic sel;
  assign sel      = is_half ? (off[1] == L[1]) : (off == L);
  assign new_byte = !sel ? old_byte : (is_half && L[0]) ? wdata[15:8] : wdata[7:0];
endmodule

module load_store_unit #(parameter int AWIDTH = 8) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  lsu,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wdata_mask,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [AWIDTH-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [31:0] rmw_q, rdata_q, merged, ld_data;
  logic        err_q, illegal_in, rmw;
  logic [1:0]  off;
  logic [15:0] sh;

  assign illegal_in = (lsu.req_size == 2'd3) ||
                      (lsu.req_size == 2'd1 && lsu.req_addr[0]) ||
                      (lsu.req_size == 2'd2 && lsu.req_addr[1:0] != 2'b00);
  assign off = req_q.addr[1:0];
  assign rmw = req_q.we && ((req_q.size == 2'd0 && off != 2'b00) ||
                            (req_q.size == 2'd1 && off[1]));

  assign lsu.req_ready  = (state == IDLE);
  assign lsu.resp_valid = (state == RESP);
  assign lsu.resp_rdata = rdata_q;
  assign lsu.resp_err   = err_q;

  // Load lane extraction and sign/zero extension.
  assign sh = 16'(mem_rdata >> {off, 3'b000});
  always_comb begin
    ld_data = mem_rdata;
    case (req_q.size)
      2'd0:    ld_data = req_q.uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    ld_data = req_q.uns ? {16'b0, sh}      : {{16{sh[15]}}, sh};
      default: ld_data = mem_rdata;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lsu_merge_lane #(.LANE(i)) u_lane (
      .is_half  (req_q.size == 2'd1),
      .off      (off),
      .wdata    (req_q.wdata[15:0]),
      .old_byte (mem_rdata[8*i +: 8]),
      .new_byte (merged[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory port is driven purely from state, so an async reset drops mem_wen at once.
  always_comb begin
    state_nxt      = state;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wdata_mask = '0;
    case (state)
      IDLE: if (lsu.req_valid) state_nxt = illegal_in ? RESP : ACCESS;
      ACCESS: begin
        mem_addr  = {req_q.addr[AWIDTH-1:2], 2'b00};
        state_nxt = rmw ? MERGE_WR : RESP;
        if (req_q.we && !rmw) begin
          mem_wen        = 1'b1;
          mem_wdata      = req_q.wdata;
          mem_wdata_mask = (req_q.size == 2'd2) ? 4'hf : (req_q.size == 2'd1) ? 4'h3 : 4'h1;
        end
      end
      MERGE_WR: begin
        mem_addr       = {req_q.addr[AWIDTH-1:2], 2'b00};
        mem_wen        = 1'b1;
        mem_wdata      = rmw_q;
        mem_wdata_mask = 4'hf;
        state_nxt      = RESP;
      end
      RESP: if (lsu.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      rmw_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && lsu.req_valid) begin
        req_q   <= '{we: lsu.req_we, size: lsu.req_size, uns: lsu.req_unsigned,
                     addr: lsu.req_addr, wdata: lsu.req_wdata};
        rdata_q <= '0;
        err_q   <= illegal_in;
      end
      if (state == ACCESS) begin
        if (!req_q.we) rdata_q <= ld_data;
        if (rmw)       rmw_q   <= merged;
      end
    end
  end

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    mem_addr[1:0] == 2'b00);
  a_mask_legal: assert property (@(posedge clk) disable iff (!rst_n)
    mem_wen ? (mem_wdata_mask inside {4'h1, 4'h3, 4'hf}) : (mem_wdata_mask == 4'h0));
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(lsu.resp_valid && lsu.req_ready));
endmodule
